// File: rtl/lock_error_gen_pkg.sv
// Shared definitions for the setpoint error stage family: the rejection
// decision encoding, the default glitch threshold and the DAC saturation
// helper used by every channel variant.
package lock_error_gen_pkg;

   // Outcome of evaluating one sample against the stored accepted error
   typedef enum logic [1:0] {
      ACCEPT = 2'd0,
      REJECT = 2'd1,
      FORCE  = 2'd2
   } decision_e;

   // Power-on threshold software loads into gpio_threshold (about 350 mV)
   localparam int unsigned DEFAULT_THRESHOLD = 163;

   // Clamp a signed value into an outWidth-bit two's complement range and
   // return it sign-extended to the 16-bit DAC bus (outWidth must be <= 16)
   function automatic logic [15:0] saturate(input logic signed [63:0] value,
                                            input int unsigned outWidth);
      logic signed [63:0] maxVal;
      logic signed [63:0] minVal;
      logic signed [63:0] clamped;
      maxVal = (64'sd1 <<< (outWidth - 1)) - 64'sd1;
      minVal = -maxVal - 64'sd1;
      if (value > maxVal) begin
         clamped = maxVal;
      end else if (value < minVal) begin
         clamped = minVal;
      end else begin
         clamped = value;
      end
      return clamped[15:0];
   endfunction

endpackage

// File: rtl/lock_error_sat.sv
// Combinational output scaler: arithmetic right shift with the shift amount
// clamped so that no more than the headroom above the DAC width is discarded,
// followed by saturation to OUT_W bits and sign extension to 16 bits.
import lock_error_gen_pkg::*;

module lock_error_sat #(
   parameter int IN_W    = 27,
   parameter int OUT_W   = 10,
   parameter int SHIFT_W = 5
) (
   input  logic signed [IN_W-1:0]    value_i,
   input  logic        [SHIFT_W-1:0] shift_i,
   output logic        [15:0]        code_o
);

   // Largest useful shift: beyond it only sign bits would remain
   localparam int unsigned MAX_SHIFT = IN_W - OUT_W;

   logic        [31:0]     shiftAmt;
   logic signed [IN_W-1:0] shifted;
   logic signed [63:0]     wideVal;

   // Clamp the shift, scale the value and saturate it to the DAC range
   always_comb begin
      shiftAmt = 32'(shift_i);
      if (shiftAmt > MAX_SHIFT) begin
         shiftAmt = MAX_SHIFT;
      end
      shifted = value_i >>> shiftAmt;
      wideVal = {{(64-IN_W){shifted[IN_W-1]}}, shifted};
      code_o  = saturate(wideVal, OUT_W);
   end

endmodule

// File: rtl/lock_error_gen.sv
// Setpoint error stage: on each trigger rising edge with a valid divider
// sample it forms setpoint - sample, rejects glitches whose step from the last
// accepted error exceeds the threshold (forcing a re-acquire after a run of
// MAX_REJECT rejections), then scales and saturates the held error for the
// DAC. Three-stage pipeline, one output pulse per evaluated event.
import lock_error_gen_pkg::*;

module lock_error_gen #(
   parameter int DATA_WIDTH = 26,
   parameter int OUT_WIDTH  = 10,
   parameter int MAX_REJECT = 4,
   parameter int SHIFT_W    = 5
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [31:0]                        S_AXIS_in_tdata,
   input  logic                               S_AXIS_in_tvalid,
   input  logic                               trigger_enable,
   input  logic [31:0]                        gpio_setpoint,
   input  logic [DATA_WIDTH-1:0]              gpio_threshold,
   input  logic [SHIFT_W-1:0]                 gpio_shift,
   output logic [15:0]                        M_AXIS_out_tdata,
   output logic                               M_AXIS_out_tvalid,
   output logic                               overload,
   output logic [$clog2(MAX_REJECT+1)-1:0]    reject_count
);

   localparam int DW   = DATA_WIDTH;
   localparam int RC_W = $clog2(MAX_REJECT + 1);

   // Edge detect state
   logic trigD_q;
   logic resetCycle_q;
   logic eventFire;

   // Stage 1: raw difference
   logic               v1_q;
   logic signed [DW:0] diff_d;
   logic signed [DW:0] diff_q;

   // Stage 2: glitch filter state
   logic                 v2_q;
   logic                 firstEvent_q;
   logic signed [DW:0]   err_d;
   logic signed [DW:0]   err_q;
   logic [RC_W-1:0]      rejectCount_d;
   logic [RC_W-1:0]      rejectCount_q;
   logic                 overload_d;
   logic                 overload_q;
   logic signed [DW+1:0] step;
   logic [DW+1:0]        stepMag;
   logic                 exceeds;
   decision_e            decision;

   // Stage 3: DAC code
   logic [15:0] satCode;
   logic [15:0] tdata_q;
   logic        tvalid_q;

   // Upper bus bits carry nothing for this sample width
   logic unusedBits;
   assign unusedBits = ^{S_AXIS_in_tdata[31:DW], gpio_setpoint[31:DW]};

   // A trigger already high when reset releases must not count as an edge,
   // so the first cycle after reset masks the detector
   assign eventFire = trigger_enable & ~trigD_q & S_AXIS_in_tvalid & ~resetCycle_q;

   // Track the previous trigger level and the post-reset mask cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         trigD_q      <= 1'b0;
         resetCycle_q <= 1'b1;
      end else begin
         trigD_q      <= trigger_enable;
         resetCycle_q <= 1'b0;
      end
   end

   // One extra bit makes setpoint - sample overflow-free
   always_comb begin
      diff_d = {gpio_setpoint[DW-1], gpio_setpoint[DW-1:0]}
             - {S_AXIS_in_tdata[DW-1], S_AXIS_in_tdata[DW-1:0]};
   end

   // Capture the difference of each triggered sample
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q   <= 1'b0;
         diff_q <= '0;
      end else begin
         v1_q <= eventFire;
         if (eventFire) begin
            diff_q <= diff_d;
         end
      end
   end

   // Judge the new difference against the accepted error and pick the update
   always_comb begin
      step    = {diff_q[DW], diff_q} - {err_q[DW], err_q};
      stepMag = step[DW+1] ? -step : step;
      exceeds = stepMag > {2'b00, gpio_threshold};

      if (firstEvent_q || !exceeds) begin
         decision = ACCEPT;
      end else if (rejectCount_q + RC_W'(1) == RC_W'(MAX_REJECT)) begin
         decision = FORCE;
      end else begin
         decision = REJECT;
      end

      err_d         = err_q;
      rejectCount_d = rejectCount_q;
      overload_d    = overload_q;
      if (v1_q) begin
         unique case (decision)
            ACCEPT: begin
               err_d         = diff_q;
               rejectCount_d = '0;
               overload_d    = 1'b0;
            end
            FORCE: begin
               err_d         = diff_q;
               rejectCount_d = '0;
               overload_d    = 1'b1;
            end
            REJECT: begin
               rejectCount_d = rejectCount_q + RC_W'(1);
               overload_d    = 1'b1;
            end
            default: begin
               err_d = err_q;
            end
         endcase
      end
   end

   // Hold the accepted error, rejection run and overload flag
   always_ff @(posedge clk) begin
      if (rst) begin
         v2_q          <= 1'b0;
         firstEvent_q  <= 1'b1;
         err_q         <= '0;
         rejectCount_q <= '0;
         overload_q    <= 1'b0;
      end else begin
         v2_q          <= v1_q;
         err_q         <= err_d;
         rejectCount_q <= rejectCount_d;
         overload_q    <= overload_d;
         if (v1_q) begin
            firstEvent_q <= 1'b0;
         end
      end
   end

   lock_error_sat #(
      .IN_W    (DW + 1),
      .OUT_W   (OUT_WIDTH),
      .SHIFT_W (SHIFT_W)
   ) u_sat (
      .value_i (err_q),
      .shift_i (gpio_shift),
      .code_o  (satCode)
   );

   // Present the scaled error for every evaluated event, accepted or not
   always_ff @(posedge clk) begin
      if (rst) begin
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
      end else begin
         tvalid_q <= v2_q;
         if (v2_q) begin
            tdata_q <= satCode;
         end
      end
   end

   assign M_AXIS_out_tdata  = tdata_q;
   assign M_AXIS_out_tvalid = tvalid_q;
   assign overload          = overload_q;
   assign reject_count      = rejectCount_q;

endmodule

// File: tb/tb_lock_error_gen.sv
// Scoreboard bench for lock_error_gen: stimulus pushes the expected DAC code,
// overload flag and rejection count from a behavioural model; a monitor pops
// and compares whenever the DUT pulses tvalid.
module tb_lock_error_gen;
   import lock_error_gen_pkg::*;

   localparam int DW  = 26;
   localparam int OW  = 10;
   localparam int MR  = 4;
   localparam int SW  = 5;
   localparam int RCW = $clog2(MR + 1);

   logic            clk;
   logic            rst;
   logic [31:0]     S_AXIS_in_tdata;
   logic            S_AXIS_in_tvalid;
   logic            trigger_enable;
   logic [31:0]     gpio_setpoint;
   logic [DW-1:0]   gpio_threshold;
   logic [SW-1:0]   gpio_shift;
   logic [15:0]     M_AXIS_out_tdata;
   logic            M_AXIS_out_tvalid;
   logic            overload;
   logic [RCW-1:0]  reject_count;

   typedef struct {
      logic [15:0]    tdata;
      logic           ovl;
      logic [RCW-1:0] cnt;
   } exp_t;

   exp_t   expQ[$];
   int     checks = 0;
   int     fails  = 0;

   longint mErr;
   int     mRun;
   bit     mFirst;

   lock_error_gen #(
      .DATA_WIDTH (DW),
      .OUT_WIDTH  (OW),
      .MAX_REJECT (MR),
      .SHIFT_W    (SW)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .S_AXIS_in_tdata   (S_AXIS_in_tdata),
      .S_AXIS_in_tvalid  (S_AXIS_in_tvalid),
      .trigger_enable    (trigger_enable),
      .gpio_setpoint     (gpio_setpoint),
      .gpio_threshold    (gpio_threshold),
      .gpio_shift        (gpio_shift),
      .M_AXIS_out_tdata  (M_AXIS_out_tdata),
      .M_AXIS_out_tvalid (M_AXIS_out_tvalid),
      .overload          (overload),
      .reject_count      (reject_count)
   );

   // 125 MHz sample clock
   initial clk = 1'b0;
   always #4 clk = ~clk;

   // Hard stop if the run never reaches its summary
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h required %0h", name, got, exp);
      end
   endtask

   function automatic longint sext26(input logic [31:0] x);
      longint v;
      v = longint'(x[DW-1:0]);
      if (v >= (longint'(1) << (DW - 1))) v = v - (longint'(1) << DW);
      return v;
   endfunction

   // Behavioural model of one evaluated event using the current gpio values
   task automatic modelEvent(input logic [31:0] sp, input logic [31:0] smp);
      longint     diff, step, mag, thr, s;
      int         sh;
      bit         ovl;
      exp_t       e;
      logic [63:0] sv;
      diff = sext26(sp) - sext26(smp);
      step = diff - mErr;
      mag  = (step < 0) ? -step : step;
      thr  = longint'(gpio_threshold);
      if (mFirst || mag <= thr) begin
         mErr = diff; mRun = 0; ovl = 1'b0;
      end else if (mRun + 1 == MR) begin
         mErr = diff; mRun = 0; ovl = 1'b1;
      end else begin
         mRun = mRun + 1; ovl = 1'b1;
      end
      mFirst = 1'b0;
      sh = int'(gpio_shift);
      if (sh > DW + 1 - OW) sh = DW + 1 - OW;
      s = mErr >>> sh;
      if (s > 511) s = 511;
      if (s < -512) s = -512;
      sv      = s;
      e.tdata = sv[15:0];
      e.ovl   = ovl;
      e.cnt   = RCW'(mRun);
      expQ.push_back(e);
   endtask

   task automatic modelReset();
      expQ.delete();
      mErr = 0; mRun = 0; mFirst = 1'b1;
   endtask

   // One trigger pulse (rising edge then low), minimum two-cycle spacing
   task automatic applyStimulus(input logic [31:0] smp, input logic [31:0] sp, input bit valid);
      @(posedge clk); #1;
      S_AXIS_in_tdata  = smp;
      gpio_setpoint    = sp;
      S_AXIS_in_tvalid = valid;
      trigger_enable   = 1'b1;
      if (valid) modelEvent(sp, smp);
      @(posedge clk); #1;
      trigger_enable   = 1'b0;
      S_AXIS_in_tvalid = 1'b0;
   endtask

   // Issue an event whose difference is exactly diff against setpoint sp
   task automatic applyDiff(input longint sp, input longint diff);
      longint smp;
      smp = sp - diff;
      applyStimulus(32'(smp), 32'(sp), 1'b1);
   endtask

   task automatic drain();
      repeat (5) @(posedge clk);
      #1;
   endtask

   // Called just after a clock edge; reset is seen on the next edge
   task automatic doReset();
      rst = 1'b1;
      modelReset();
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Monitor: compare every output pulse with the head of the scoreboard
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && M_AXIS_out_tvalid) begin
         if (expQ.size() == 0) begin
            checkOutput("spurious_tvalid", 32'(M_AXIS_out_tvalid), 32'd0);
         end else begin
            e = expQ.pop_front();
            checkOutput("tdata", 32'(M_AXIS_out_tdata), 32'(e.tdata));
            checkOutput("overload", 32'(overload), 32'(e.ovl));
            checkOutput("reject_count", 32'(reject_count), 32'(e.cnt));
         end
      end
   end

   initial begin
      longint sp, d, prev;
      rst = 1'b1; trigger_enable = 1'b0; S_AXIS_in_tvalid = 1'b0;
      S_AXIS_in_tdata = '0; gpio_setpoint = '0;
      gpio_threshold = DW'(DEFAULT_THRESHOLD); gpio_shift = SW'(11);
      modelReset();
      repeat (3) @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_tdata", 32'(M_AXIS_out_tdata), 32'd0);
      checkOutput("reset_tvalid", 32'(M_AXIS_out_tvalid), 32'd0);
      checkOutput("reset_overload", 32'(overload), 32'd0);
      checkOutput("reset_count", 32'(reject_count), 32'd0);

      // Basic path: small error scaled away, then larger error after threshold opened
      applyStimulus(32'h000F_FF00, 32'h0010_0000, 1'b1);
      drain();
      gpio_threshold = '1;
      applyStimulus(32'h000C_0000, 32'h0010_0000, 1'b1);
      drain();

      // Glitch then recovery
      gpio_shift = '0;
      applyDiff(0, 0);
      drain();
      gpio_threshold = DW'(DEFAULT_THRESHOLD);
      applyDiff(0, 500);
      applyDiff(0, 100);
      // Forced relock after a run of rejections
      for (int i = 0; i < 4; i++) applyDiff(0, 5000);
      drain();

      // Saturation at both rails
      gpio_threshold = '1;
      applyStimulus(32'h0200_0000, 32'h01FF_FFFF, 1'b1);
      applyStimulus(32'h01FF_FFFF, 32'h0200_0000, 1'b1);
      // Step equal to the threshold is accepted
      applyDiff(0, 0);
      drain();
      gpio_threshold = DW'(DEFAULT_THRESHOLD);
      applyDiff(0, 163);
      applyDiff(0, 0);
      applyDiff(0, 164);
      drain();

      // Shift beyond the headroom is clamped
      gpio_threshold = '1; gpio_shift = SW'(31);
      applyDiff(0, longint'(1) << 25);
      applyDiff(0, -(longint'(1) << 25));
      drain();

      // Edge without tvalid is dropped; held trigger gives one event
      applyStimulus(32'h0000_1234, 32'h0, 1'b0);
      @(posedge clk); #1;
      S_AXIS_in_tdata = 32'h0000_0100; gpio_setpoint = 32'h0;
      S_AXIS_in_tvalid = 1'b1; trigger_enable = 1'b1;
      modelEvent(gpio_setpoint, S_AXIS_in_tdata);
      repeat (10) @(posedge clk); #1;
      trigger_enable = 1'b0; S_AXIS_in_tvalid = 1'b0;
      drain();

      // Reset mid-flight flushes the event; next event accepted at threshold 0
      gpio_shift = '0;
      applyDiff(0, 300);
      doReset();
      @(negedge clk);
      checkOutput("flush_tdata", 32'(M_AXIS_out_tdata), 32'd0);
      checkOutput("flush_overload", 32'(overload), 32'd0);
      checkOutput("flush_count", 32'(reject_count), 32'd0);
      drain();
      gpio_threshold = '0;
      applyDiff(0, 400);
      applyDiff(0, 401);
      drain();

      // Trigger high across reset release must not fire
      @(posedge clk); #1;
      trigger_enable = 1'b1; S_AXIS_in_tvalid = 1'b1;
      doReset();
      repeat (5) @(posedge clk); #1;
      trigger_enable = 1'b0; S_AXIS_in_tvalid = 1'b0;
      drain();
      applyDiff(0, -250);
      drain();

      // Randomised bursts of back-to-back events
      for (int b = 0; b < 6; b++) begin
         gpio_threshold = DW'($urandom_range(0, 3000));
         gpio_shift     = SW'($urandom_range(0, 31));
         sp   = longint'($urandom_range(0, 1 << 24)) - (longint'(1) << 23);
         prev = mErr;
         for (int k = 0; k < 20; k++) begin
            if ($urandom_range(0, 7) == 0) begin
               d = prev + longint'($urandom_range(5000, 100000)) * (($urandom_range(0, 1) == 0) ? 1 : -1);
            end else begin
               d = prev + longint'($urandom_range(0, 2 * int'(gpio_threshold) + 200))
                        - longint'(gpio_threshold) - 100;
            end
            if (d > 4000000 || d < -4000000) d = 0;
            if ($urandom_range(0, 7) == 0) begin
               applyStimulus(32'(sp - d), 32'(sp), 1'b0);
            end else begin
               applyDiff(sp, d);
               prev = mErr;
            end
         end
         drain();
      end

      repeat (10) @(posedge clk);
      @(negedge clk);
      checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
